// File: rtl/e_pkg.sv
// Shared types and constants for the e-calculation datapath (limbs, multi-word numbers, arbiter states).
package e_pkg;
  localparam int E_WORDS = 32;
  localparam int LIMB_W  = 16;

  typedef logic [LIMB_W-1:0] limb_t;
  typedef limb_t [E_WORDS-1:0] e_num_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
endpackage

// File: rtl/e_rr_pick.sv
// Combinational round-robin picker: first set request at rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
module e_rr_pick import e_pkg::*; #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any_valid
);

  // Scan from the farthest offset down so the nearest request to rr_ptr wins.
  always_comb begin
    int idx;
    winner = '0;
    idx    = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) winner = IDW'(idx);
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/e_multi_arbiter.sv
// Round-robin arbiter sharing one e_multi multiplier among NREQ requesters.
// Optional watchdog in WAIT is enabled with `define E_ARB_TIMEOUT_EN.
module e_multi_arbiter import e_pkg::*; #(
  parameter int WORDS       = E_WORDS,
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NREQ-1:0]                       req,
  input  logic [NREQ-1:0][WORDS-1:0][LIMB_W-1:0] req_a,
  input  logic [NREQ-1:0][WORDS-1:0][LIMB_W-1:0] req_b,
  output logic [NREQ-1:0]                       ack,
  output logic [WORDS-1:0][LIMB_W-1:0]          res,
  output logic [IDW-1:0]                        gnt_id,
  output logic                                  busy,
  output logic                                  m_start,
  output logic [WORDS-1:0][LIMB_W-1:0]          m_a,
  output logic [WORDS-1:0][LIMB_W-1:0]          m_b,
  input  logic                                  m_done,
  input  logic [WORDS-1:0][LIMB_W-1:0]          m_product,
  output logic                                  err
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  arb_state_t     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           any_valid;
  logic           wait_first;
  logic           done_seen;
  logic           timed_out;

  e_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The first WAIT cycle masks a done level left over from the previous operation.
  assign done_seen = (state == WAIT) && !wait_first && m_done;
  assign busy      = (state != IDLE);

`ifdef E_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !done_seen;

  // wait_cnt holds the index of the current WAIT cycle, starting at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err      <= timed_out;
      wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
    end
  end
`else
  assign timed_out = 1'b0;
  // Watchdog compiled out: err is constant low.
  assign err = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      m_start    <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
      res        <= '0;
      ack        <= '0;
      wait_first <= 1'b0;
    end else begin
      ack     <= '0;
      m_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            m_a     <= req_a[winner];
            m_b     <= req_b[winner];
            gnt_id  <= winner;
            m_start <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          wait_first <= 1'b0;
          if (done_seen || timed_out) begin
            if (done_seen) res <= m_product;
            ack    <= NREQ'(1) << gnt_id;
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_multi_arbiter.sv
// Bench for e_multi_arbiter: directed scenarios then random traffic, checked each cycle against a
// transaction-level reference built from the round-robin and latency rules.
`timescale 1ns/1ps
module tb_e_multi_arbiter;
  localparam int NREQ        = 2;
  localparam int WORDS       = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int IDW         = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             rst_n;
  logic [NREQ-1:0]                  req;
  logic [NREQ-1:0][WORDS-1:0][15:0] req_a, req_b;
  logic [NREQ-1:0]                  ack;
  logic [WORDS-1:0][15:0]           res, m_a, m_b, m_product;
  logic [IDW-1:0]                   gnt_id;
  logic                             busy, m_start, m_done, err;

  e_multi_arbiter #(.WORDS(WORDS), .NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .res(res), .gnt_id(gnt_id), .busy(busy), .m_start(m_start),
    .m_a(m_a), .m_b(m_b), .m_done(m_done), .m_product(m_product), .err(err)
  );

  // Multiplier stand-in: done rises cur_lat edges after the start edge (cur_lat=0: never).
  // In level mode done stays high until the cycle after the next start, exercising the stale mask.
  int          cur_lat;
  bit          pulse_mode;
  logic        mul_busy, start_d;
  int          rem;
  logic [31:0] op_a, op_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0; m_product <= '0; mul_busy <= 1'b0; start_d <= 1'b0;
      rem <= 0; op_a <= '0; op_b <= '0;
    end else begin
      start_d <= m_start;
      if (m_start) begin
        mul_busy <= (cur_lat != 0);
        rem      <= cur_lat;
        op_a     <= m_a;
        op_b     <= m_b;
      end else if (mul_busy && rem == 1) begin
        m_done    <= 1'b1;
        m_product <= op_a * op_b;
        mul_busy  <= 1'b0;
      end else begin
        if (mul_busy) rem <= rem - 1;
        if (start_d || (pulse_mode && m_done)) m_done <= 1'b0;
      end
    end
  end

  int              cyc, vectors, miscompares;
  bit              exp_busy, pending, is_to, exp_err, exp_mstart, timeout_mode;
  logic [NREQ-1:0] exp_ack;
  int              ref_ptr, exp_gnt, start_cyc, ack_cyc;
  logic [31:0]     exp_res, exp_ma, exp_mb, exp_prod;
  bit              hold_mode, rand_mode;
  bit [NREQ-1:0]   withdrawn;
  int              grants[$];
  int              starts;

  function automatic int pickRr(logic [NREQ-1:0] r, int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  // Reference: grant when idle and any request; ack at start+lat+2 (or start+TIMEOUT_CYC+1).
  task automatic refUpdate();
    bit          prev_busy;
    int          w;
    logic [31:0] a_w, b_w;
    if (!rst_n) begin
      pending = 0; exp_busy = 0; exp_ack = '0; exp_res = '0; exp_gnt = 0;
      exp_ma = '0; exp_mb = '0; ref_ptr = 0; exp_err = 0; exp_mstart = 0;
      return;
    end
    prev_busy = exp_busy;
    exp_ack   = '0;
    exp_err   = 0;
    if (!prev_busy && req != '0) begin
      w         = pickRr(req, ref_ptr);
      a_w       = req_a[w];
      b_w       = req_b[w];
      exp_gnt   = w;
      exp_ma    = a_w;
      exp_mb    = b_w;
      exp_prod  = a_w * b_w;
      start_cyc = cyc;
      is_to     = timeout_mode;
      ack_cyc   = is_to ? cyc + TIMEOUT_CYC + 1 : cyc + cur_lat + 2;
      pending   = 1;
    end
    if (pending && cyc == ack_cyc) begin
      exp_ack = NREQ'(1) << exp_gnt;
      if (!is_to) exp_res = exp_prod;
      exp_err = is_to;
      ref_ptr = (exp_gnt + 1) % NREQ;
      pending = 0;
    end
    exp_busy   = pending;
    exp_mstart = pending && (cyc == start_cyc);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ack[i]) begin
        withdrawn[i] = 1'b0;
        if (hold_mode) begin
          req_a[i] = $urandom; req_b[i] = $urandom;
        end else begin
          req[i] = 1'b0;
        end
      end else if (rand_mode) begin
        if (!req[i] && !withdrawn[i] && $urandom_range(0, 99) < 40) begin
          req[i] = 1'b1; req_a[i] = $urandom; req_b[i] = $urandom;
        end else if (req[i] && pending && exp_gnt == i && cyc > start_cyc &&
                     $urandom_range(0, 99) < 10) begin
          req[i] = 1'b0; withdrawn[i] = 1'b1; req_a[i] = $urandom;
        end
      end
    end
    if (rand_mode && !exp_busy) begin
      cur_lat    = $urandom_range(1, 6);
      pulse_mode = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    cyc++;
    refUpdate();
    checkOutput("ack",     64'(ack),     64'(exp_ack));
    checkOutput("busy",    64'(busy),    64'(exp_busy));
    checkOutput("m_start", 64'(m_start), 64'(exp_mstart));
    checkOutput("gnt_id",  64'(gnt_id),  64'(exp_gnt));
    checkOutput("res",     64'(res),     64'(exp_res));
    checkOutput("m_a",     64'(m_a),     64'(exp_ma));
    checkOutput("m_b",     64'(m_b),     64'(exp_mb));
    checkOutput("err",     64'(err),     64'(exp_err));
    if (m_start === 1'b1) begin
      starts++;
      grants.push_back(int'(gnt_id));
    end
    applyStimulus();
  endtask

  task automatic runOp(int maxc);
    int n = 0;
    bit got = 0;
    while (n < maxc && !got) begin
      stepCycle();
      got = (exp_ack != '0);
      n++;
    end
  endtask

  task automatic waitStart(int maxc);
    int n = 0;
    bit got = 0;
    while (n < maxc && !got) begin
      stepCycle();
      got = (m_start === 1'b1);
      n++;
    end
    if (!got) checkOutput("start_seen", 64'(got), 64'(1));
  endtask

  logic [31:0] res_before;
  int          st;

  initial begin
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0;
    cur_lat = 3; pulse_mode = 0; hold_mode = 0; rand_mode = 0; timeout_mode = 0;
    withdrawn = '0; cyc = 0; vectors = 0; miscompares = 0; starts = 0;
    pending = 0; exp_busy = 0; exp_ack = '0; exp_res = '0; exp_gnt = 0; ref_ptr = 0;
    exp_ma = '0; exp_mb = '0; exp_err = 0; exp_mstart = 0;

    // Reset state.
    stepCycle(); stepCycle();
    rst_n = 1'b1;

    // Simultaneous held requests from rr_ptr=0: grants 0, 1, 0.
    $display("[TB] simultaneous requests");
    grants.delete();
    req_a[0] = 32'h7; req_b[0] = 32'h9; req_a[1] = 32'h11; req_b[1] = 32'h3;
    cur_lat = 2; hold_mode = 1; req = 2'b11;
    runOp(30); runOp(30); runOp(30);
    hold_mode = 0; req = '0;
    checkOutput("grant_count", 64'(grants.size()), 64'(3));
    for (int i = 0; i < grants.size() && i < 3; i++)
      checkOutput("grant_order", 64'(grants[i]), 64'((i == 1) ? 1 : 0));
    stepCycle(); stepCycle();

    // Single requester: 3 * 5.
    $display("[TB] single requester");
    starts = 0;
    req_a[0] = 32'h0000_0003; req_b[0] = 32'h0000_0005; cur_lat = 3; req = 2'b01;
    runOp(20);
    checkOutput("single_res", 64'(res), 64'h0000_000F);
    checkOutput("single_gnt", 64'(gnt_id), 64'(0));
    checkOutput("single_starts", 64'(starts), 64'(1));
    stepCycle(); stepCycle();

    // Stale done level still high from the previous operation.
    $display("[TB] stale done");
    req_a[0] = 32'h0000_1234; req_b[0] = 32'h0000_0010; cur_lat = 4; req = 2'b01;
    runOp(20);
    checkOutput("stale_res", 64'(res), 64'h0001_2340);
    stepCycle();

    // Requester 1 withdraws two cycles after the grant.
    $display("[TB] withdrawn request");
    req_a[1] = 32'h0001_0001; req_b[1] = 32'h0000_0003; cur_lat = 5; req = 2'b10;
    waitStart(10);
    stepCycle(); stepCycle();
    req[1] = 1'b0; withdrawn[1] = 1'b1; req_b[1] = 32'h0000_FFFF;
    runOp(20);
    checkOutput("withdraw_res", 64'(res), 64'h0003_0003);
    stepCycle();

    // Reset mid-WAIT, then requester 1 alone is granted from rr_ptr=0.
    $display("[TB] reset mid-WAIT");
    req_a[0] = $urandom; req_b[0] = $urandom; cur_lat = 6; req = 2'b01;
    waitStart(10);
    stepCycle(); stepCycle();
    rst_n = 1'b0; req = 2'b10;
    stepCycle(); stepCycle();
    rst_n = 1'b1;
    cur_lat = 2;
    waitStart(10);
    checkOutput("post_reset_gnt", 64'(gnt_id), 64'(1));
    runOp(20);
    stepCycle();

    // Random traffic.
    $display("[TB] random traffic");
    rand_mode = 1;
    repeat (800) stepCycle();
    rand_mode = 0; req = '0;
    repeat (20) stepCycle();
    withdrawn = '0;

`ifdef E_ARB_TIMEOUT_EN
    // Multiplier never completes: err and ack together, res unchanged.
    $display("[TB] watchdog timeout");
    res_before = exp_res;
    timeout_mode = 1; cur_lat = 0;
    req_a[1] = 32'h5; req_b[1] = 32'h6; req = 2'b10;
    waitStart(10);
    st = cyc;
    runOp(40);
    checkOutput("to_latency", 64'(cyc - st), 64'(TIMEOUT_CYC + 1));
    checkOutput("to_err", 64'(err), 64'(1));
    checkOutput("to_res", 64'(res), 64'(res_before));
    timeout_mode = 0; cur_lat = 2;
    req_a[0] = 32'h0000_0021; req_b[0] = 32'h0000_0002; req = 2'b01;
    runOp(20);
    checkOutput("after_to_res", 64'(res), 64'h0000_0042);
    stepCycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/e_multi_arbiter.md
Name: e_multi_arbiter

Overview:
- Shares one e_multi multi-word multiplier among NREQ requesters using round-robin arbitration. Typical requesters are the repeated-squaring engine and the (1+1/N) term builder.
- Latches the winner's operands, pulses the multiplier start, waits for done, then returns the product and a one-cycle acknowledge to the winner.
- Sits between the e-calculation sequencers and the single multiplier instance.

Parameters:
- WORDS, 32, number of 16-bit limbs per operand/product
- NREQ, 2, number of requesters (2..8)
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req  in  NREQ  per-requester request level; held until matching ack
- req_a  in  NREQ x WORDS x 16  operand A per requester
- req_b  in  NREQ x WORDS x 16  operand B per requester
- ack  out  NREQ  one-hot, one-cycle pulse: result valid for that requester
- res  out  WORDS x 16  last product; stable until next ack
- gnt_id  out  $clog2(NREQ)  index of current/last granted requester
- busy  out  1  high whenever state is not IDLE
- m_start  out  1  multiplier start pulse
- m_a, m_b  out  WORDS x 16  latched operands to multiplier
- m_done  in  1  multiplier done (level or pulse)
- m_product  in  WORDS x 16  multiplier result
- err  out  1  timeout pulse (only with E_ARB_TIMEOUT_EN; tied 0 otherwise)

Behaviour:
- Reset values: ack=0, res=0, gnt_id=0, busy=0, m_start=0, m_a=m_b=0, err=0, rr_ptr=0, state=IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If req != 0, winner = first set bit at index rr_ptr, rr_ptr+1, ... wrapping modulo NREQ.
  - Same edge: m_a <= req_a[winner], m_b <= req_b[winner], gnt_id <= winner; go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE: m_start=1 for exactly this one cycle; go to WAIT. m_done is ignored here.
- WAIT:
  - m_done is ignored in the first WAIT cycle, so a stale level done from the previous operation is masked. It is sampled from the second WAIT cycle on.
  - On sampled m_done: res <= m_product, ack[gnt_id] <= 1 for the next cycle only, rr_ptr <= (gnt_id+1) mod NREQ; go to IDLE.
- Latency: grant edge to m_start is 1 cycle. ack rises 1 cycle after the m_done sample. Minimum turnaround is 4 cycles from req to ack with an ideal multiplier.
- A new grant may occur in the same cycle ack is high. The acked requester must drop req in that cycle; a req still high there is treated as a new request, subject to round-robin.
- Requests arriving while busy are not granted until IDLE.
- req dropped mid-operation: the operation still completes and ack is still issued; operands are already latched.
- Simultaneous requests: resolved strictly by rr_ptr. A requester that continuously requests never starves (at most NREQ-1 waits).
- rst_n asserted mid-operation: all registers return to reset values immediately; m_start deasserts; no ack is issued.
- m_done while in IDLE or ISSUE: ignored.

Optional Feature:
- Macro: E_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT. If it reaches TIMEOUT_CYC without a sampled m_done, err pulses for 1 cycle and ack[gnt_id] pulses in the same cycle.
  - res is left unchanged, rr_ptr advances, and the state returns to IDLE.
- Undefined: no counter; WAIT waits indefinitely; err is tied 0.

Decomposition:
- Package e_pkg holds:
  - limb_t (logic [15:0]) and the WORDS-limb array type
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - default WORDS constant
- One sub-module, e_rr_pick: purely combinational round-robin picker (req, rr_ptr -> winner index, any_valid). It is reused by other schedulers.

Test Plan:
- Single requester: NREQ=2, WORDS=2, req=2'b01, A={0x0000,0x0003}, B={0x0000,0x0005}, multiplier model done after 3 cycles -> one m_start pulse, ack=2'b01 one cycle, res={0x0000,0x000F}, gnt_id=0.
- Simultaneous requests: req=2'b11 held, rr_ptr=0 -> grants in order 0, 1, 0; each ack one-hot; busy low for at most one cycle between operations.
- Stale level done: multiplier model holds m_done=1 from the previous operation until the next m_start -> no early ack; ack only after the genuine completion.
- Request withdrawn: req[1] drops two cycles after grant -> operation completes, ack[1] still pulses, res = correct product.
- Reset mid-WAIT: rst_n low for 2 cycles -> all outputs are 0 and there is no ack. After release with req=2'b10 -> grant 1 (rr_ptr=0, bit0 idle).
- With E_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, the multiplier never asserts done -> err and ack pulse together exactly 16 cycles into WAIT, res is unchanged, and the arbiter then services the next request.
